// File: rtl/picorv_mem_ctrl.sv
// Memory-bus controller for the picorv32 native interface: decodes RAM / UART / unmapped
// accesses, sequences the RAM read latency and UART handshake, and arbitrates loader writes.
module picorv_mem_ctrl #(
    parameter int unsigned RamWords    = 256,
    parameter logic [31:0] UartBase    = 32'h1000_0000,
    parameter int unsigned LdrBurstMax = 4
) (
    input  logic                        clk_i,
    input  logic                        reset_ni,
    input  logic                        mem_valid_i,
    input  logic                        mem_instr_i,
    input  logic [31:0]                 mem_addr_i,
    input  logic [31:0]                 mem_wdata_i,
    input  logic [3:0]                  mem_wstrb_i,
    output logic                        mem_ready_o,
    output logic [31:0]                 mem_rdata_o,
    input  logic                        ldr_valid_i,
    input  logic [$clog2(RamWords)-1:0] ldr_addr_i,
    input  logic [31:0]                 ldr_wdata_i,
    output logic                        ldr_ready_o,
    output logic [$clog2(RamWords)-1:0] ram_addr_o,
    output logic [3:0]                  ram_wr_en_o,
    output logic [31:0]                 ram_wr_data_o,
    input  logic [31:0]                 ram_rd_data_i,
    output logic                        uart_valid_o,
    output logic                        uart_we_o,
    output logic [1:0]                  uart_addr_o,
    output logic [31:0]                 uart_wdata_o,
    input  logic                        uart_ready_i,
    input  logic [31:0]                 uart_rdata_i,
    output logic                        err_o
);
    localparam int unsigned AddrW   = $clog2(RamWords);
    localparam int unsigned BurstW  = $clog2(LdrBurstMax + 1);
    localparam logic [31:0] RamBytes = 32'(RamWords * 4);
    localparam logic [BurstW-1:0] BurstMax = BurstW'(LdrBurstMax);

    typedef enum logic [1:0] {IDLE, RD_WAIT, UART_WAIT, RESP} state_e;

    state_e              state_q, state_d;
    logic [BurstW-1:0]   burst_q;
    logic [31:0]         rdata_q;
    logic                err_q;
    logic                uart_we_q;
    logic [1:0]          uart_addr_q;
    logic [31:0]         uart_wdata_q;

    logic ram_hit, uart_hit, ldr_grant, cpu_grant;

    // The CPU only issues word-aligned requests and mem_instr_i carries no routing meaning.
    logic unused_sig;
    assign unused_sig = ^{mem_instr_i, mem_addr_i[1:0]};

    assign ram_hit  = mem_addr_i < RamBytes;
    assign uart_hit = (mem_addr_i >= UartBase) && (mem_addr_i < UartBase + 32'd16);

    // Loader yields only once it has used its burst allowance against a waiting CPU.
    assign ldr_grant = (state_q == IDLE) && ldr_valid_i && !(mem_valid_i && burst_q == BurstMax);
    assign cpu_grant = (state_q == IDLE) && mem_valid_i && !ldr_grant;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (cpu_grant) begin
                    if (ram_hit)       state_d = (mem_wstrb_i != 4'b0) ? RESP : RD_WAIT;
                    else if (uart_hit) state_d = UART_WAIT;
                    else               state_d = RESP;
                end
            end
            RD_WAIT:   state_d = RESP;
            UART_WAIT: if (uart_ready_i) state_d = RESP;
            RESP:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        ldr_ready_o   = ldr_grant;
        ram_wr_en_o   = 4'b0;
        ram_addr_o    = mem_addr_i[AddrW+1:2];
        ram_wr_data_o = mem_wdata_i;
        if (ldr_grant) begin
            ram_wr_en_o   = 4'hF;
            ram_addr_o    = ldr_addr_i;
            ram_wr_data_o = ldr_wdata_i;
        end else if (cpu_grant && ram_hit) begin
            ram_wr_en_o   = mem_wstrb_i;
        end
        mem_ready_o  = (state_q == RESP);
        uart_valid_o = (state_q == UART_WAIT);
        uart_we_o    = (state_q == UART_WAIT) && uart_we_q;
        uart_addr_o  = uart_addr_q;
        uart_wdata_o = uart_wdata_q;
        mem_rdata_o  = rdata_q;
        err_o        = err_q;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            burst_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            uart_we_q    <= 1'b0;
            uart_addr_q  <= '0;
            uart_wdata_q <= '0;
        end else begin
            if (!mem_valid_i || cpu_grant)            burst_q <= '0;
            else if (ldr_grant && burst_q != BurstMax) burst_q <= burst_q + 1'b1;

            // UART request fields are captured at grant so they stay stable for the handshake.
            if (cpu_grant) begin
                uart_we_q    <= (mem_wstrb_i != 4'b0);
                uart_addr_q  <= mem_addr_i[3:2];
                uart_wdata_q <= mem_wdata_i;
                if (!ram_hit && !uart_hit) begin
                    err_q   <= 1'b1;
                    rdata_q <= '0;
                end
            end
            if (state_q == RD_WAIT) rdata_q <= ram_rd_data_i;
            if (state_q == UART_WAIT && uart_ready_i) rdata_q <= uart_we_q ? 32'd0 : uart_rdata_i;
        end
    end
endmodule

// File: tb/tb_picorv_mem_ctrl.sv
// Directed bench for picorv_mem_ctrl: behavioural RAM model, hand-computed expectations,
// immediate assertions at each comparison point.
module tb_picorv_mem_ctrl;
    localparam int unsigned RamWords = 256;
    localparam int unsigned AW       = 8;
    localparam logic [31:0] UartBase = 32'h1000_0000;

    logic          clk_i = 1'b0;
    logic          reset_ni = 1'b0;
    logic          mem_valid_i = 1'b0, mem_instr_i = 1'b0;
    logic [31:0]   mem_addr_i = '0, mem_wdata_i = '0;
    logic [3:0]    mem_wstrb_i = '0;
    logic          mem_ready_o;
    logic [31:0]   mem_rdata_o;
    logic          ldr_valid_i = 1'b0;
    logic [AW-1:0] ldr_addr_i = '0;
    logic [31:0]   ldr_wdata_i = '0;
    logic          ldr_ready_o;
    logic [AW-1:0] ram_addr_o;
    logic [3:0]    ram_wr_en_o;
    logic [31:0]   ram_wr_data_o;
    logic [31:0]   ram_rd_data_i = '0;
    logic          uart_valid_o, uart_we_o;
    logic [1:0]    uart_addr_o;
    logic [31:0]   uart_wdata_o;
    logic          uart_ready_i = 1'b0;
    logic [31:0]   uart_rdata_i = '0;
    logic          err_o;

    int total = 0;
    int bad   = 0;

    picorv_mem_ctrl #(.RamWords(RamWords), .UartBase(UartBase), .LdrBurstMax(4)) dut (
        .clk_i(clk_i), .reset_ni(reset_ni),
        .mem_valid_i(mem_valid_i), .mem_instr_i(mem_instr_i), .mem_addr_i(mem_addr_i),
        .mem_wdata_i(mem_wdata_i), .mem_wstrb_i(mem_wstrb_i),
        .mem_ready_o(mem_ready_o), .mem_rdata_o(mem_rdata_o),
        .ldr_valid_i(ldr_valid_i), .ldr_addr_i(ldr_addr_i), .ldr_wdata_i(ldr_wdata_i),
        .ldr_ready_o(ldr_ready_o),
        .ram_addr_o(ram_addr_o), .ram_wr_en_o(ram_wr_en_o), .ram_wr_data_o(ram_wr_data_o),
        .ram_rd_data_i(ram_rd_data_i),
        .uart_valid_o(uart_valid_o), .uart_we_o(uart_we_o), .uart_addr_o(uart_addr_o),
        .uart_wdata_o(uart_wdata_o), .uart_ready_i(uart_ready_i), .uart_rdata_i(uart_rdata_i),
        .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    // Synchronous 1R1W RAM, zero-initialised, one-cycle read latency.
    logic [31:0] ram [RamWords];
    initial for (int i = 0; i < int'(RamWords); i++) ram[i] = '0;
    always @(posedge clk_i) begin
        for (int b = 0; b < 4; b++)
            if (ram_wr_en_o[b]) ram[ram_addr_o][8*b +: 8] <= ram_wr_data_o[8*b +: 8];
        ram_rd_data_i <= ram[ram_addr_o];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One CPU transaction, also acting as UART responder (ready in valid cycle udelay+1).
    // Starts just after a rising edge; lat is the cycle index (0 = first request cycle) of mem_ready_o.
    task automatic cpu_access(input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wstrb, input int udelay, input logic [31:0] urdata,
                              output logic [31:0] rdata, output int lat, output int vcnt,
                              output int vgood, output int wen_cnt, output logic ok);
        mem_valid_i = 1'b1; mem_addr_i = addr; mem_wdata_i = wdata; mem_wstrb_i = wstrb;
        uart_rdata_i = urdata; uart_ready_i = 1'b0;
        ok = 1'b0; lat = -1; vcnt = 0; vgood = 0; wen_cnt = 0; rdata = 'x;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk_i);
            if (ram_wr_en_o != 4'b0) wen_cnt++;
            if (uart_valid_o) begin
                vcnt++;
                if (uart_we_o == (wstrb != 4'b0) && uart_addr_o == addr[3:2] &&
                    (wstrb == 4'b0 || uart_wdata_o == wdata)) vgood++;
            end
            if (mem_ready_o) begin rdata = mem_rdata_o; lat = c; ok = 1'b1; end
            @(posedge clk_i); #1;
            if (ok) begin
                mem_valid_i = 1'b0; mem_wstrb_i = 4'b0; uart_ready_i = 1'b0;
                break;
            end
            uart_ready_i = uart_valid_o && (vcnt == udelay);
        end
        if (!ok) begin
            mem_valid_i = 1'b0; mem_wstrb_i = 4'b0; uart_ready_i = 1'b0;
        end
    endtask

    // Loader and CPU both requesting continuously for 14 cycles; per-cycle event bitmaps.
    task automatic arb_phase(input logic [31:0] addr, output logic [13:0] lmap,
                             output logic [13:0] rmap, output logic [13:0] umap,
                             output logic [31:0] last_rdata);
        ldr_valid_i = 1'b1; ldr_addr_i = 8'd20; ldr_wdata_i = 32'h1234_5678;
        mem_valid_i = 1'b1; mem_addr_i = addr; mem_wstrb_i = 4'b0;
        lmap = '0; rmap = '0; umap = '0; last_rdata = 'x;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk_i);
            lmap[c] = ldr_ready_o;
            rmap[c] = mem_ready_o;
            umap[c] = uart_valid_o;
            if (mem_ready_o) last_rdata = mem_rdata_o;
            @(posedge clk_i); #1;
        end
        ldr_valid_i = 1'b0; mem_valid_i = 1'b0;
        @(posedge clk_i); #1;
    endtask

    logic [31:0] prog [6];
    logic [31:0] rd;
    int lat, vcnt, vgood, wen, rdy_cnt;
    logic ok;
    logic [13:0] lmap, rmap, umap;

    initial begin
        prog = '{32'h3fc00093, 32'h0000a023, 32'h0000a103,
                 32'h00110113, 32'h0020a023, 32'hff5ff06f};

        // Reset state.
        #12;
        check("rst_mem_ready", 32'(mem_ready_o), 32'd0);
        check("rst_ldr_ready", 32'(ldr_ready_o), 32'd0);
        check("rst_uart_valid", 32'(uart_valid_o), 32'd0);
        check("rst_uart_we", 32'(uart_we_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_ram_wr_en", 32'(ram_wr_en_o), 32'd0);
        check("rst_mem_rdata", mem_rdata_o, 32'd0);
        @(negedge clk_i); reset_ni = 1'b1;
        @(posedge clk_i); #1;

        // Program load through the loader while the CPU is idle.
        for (int i = 0; i < 6; i++) begin
            ldr_valid_i = 1'b1; ldr_addr_i = AW'(i); ldr_wdata_i = prog[i];
            @(negedge clk_i);
            check($sformatf("ldr_grant_%0d", i), 32'(ldr_ready_o), 32'd1);
            check($sformatf("ldr_wren_%0d", i), 32'(ram_wr_en_o), 32'hF);
            @(posedge clk_i); #1;
        end
        ldr_valid_i = 1'b0;

        // Instruction fetches: data as loaded, ready two cycles after the grant.
        mem_instr_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cpu_access(32'(i * 4), 32'd0, 4'b0, 0, 32'd0, rd, lat, vcnt, vgood, wen, ok);
            check($sformatf("fetch_data_%0d", i), rd, prog[i]);
            check($sformatf("fetch_lat_%0d", i), 32'(lat), 32'd2);
        end
        mem_instr_i = 1'b0;

        // Loop body of the loaded program: counter at 0x3FC counts 0,1,2,...
        cpu_access(32'h3FC, 32'd0, 4'hF, 0, 32'd0, rd, lat, vcnt, vgood, wen, ok);
        check("loop_init_lat", 32'(lat), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cpu_access(32'h3FC, 32'd0, 4'b0, 0, 32'd0, rd, lat, vcnt, vgood, wen, ok);
            check($sformatf("loop_lw_%0d", i), rd, 32'(i));
            cpu_access(32'h3FC, 32'(i + 1), 4'hF, 0, 32'd0, rd, lat, vcnt, vgood, wen, ok);
        end

        // Partial write over zeroed word, then read back.
        cpu_access(32'h3FC, 32'd0, 4'hF, 0, 32'd0, rd, lat, vcnt, vgood, wen, ok);
        cpu_access(32'h3FC, 32'hDEAD_BEEF, 4'b0011, 0, 32'd0, rd, lat, vcnt, vgood, wen, ok);
        check("wr_lat", 32'(lat), 32'd1);
        cpu_access(32'h3FC, 32'd0, 4'b0, 0, 32'd0, rd, lat, vcnt, vgood, wen, ok);
        check("rd_strobe_data", rd, 32'h0000_BEEF);
        check("rd_lat", 32'(lat), 32'd2);

        // UART write, handshake delayed by 5 cycles.
        cpu_access(UartBase, 32'h41, 4'hF, 5, 32'd0, rd, lat, vcnt, vgood, wen, ok);
        check("uart_wr_done", 32'(ok), 32'd1);
        check("uart_wr_valid_cycles", 32'(vcnt), 32'd6);
        check("uart_wr_stable", 32'(vgood), 32'd6);
        check("uart_wr_lat", 32'(lat), 32'd7);
        check("uart_wr_rdata", rd, 32'd0);
        cpu_access(UartBase + 32'd4, 32'd0, 4'b0, 1, 32'h5A, rd, lat, vcnt, vgood, wen, ok);
        check("uart_rd_data", rd, 32'h5A);
        check("uart_rd_stable", 32'(vgood), 32'd2);
        check("uart_rd_lat", 32'(lat), 32'd3);

        // Arbitration: 4 loader grants then one CPU grant; none while the CPU is in flight.
        arb_phase(32'h0, lmap, rmap, umap, rd);
        check("arb_ram_ldr_map", 32'(lmap), 32'h078F);
        check("arb_ram_rdy_map", 32'(rmap), 32'h2040);
        check("arb_ram_rdata", rd, 32'h3fc00093);
        uart_ready_i = 1'b1; uart_rdata_i = 32'hA5;
        arb_phase(UartBase + 32'd8, lmap, rmap, umap, rd);
        uart_ready_i = 1'b0;
        check("arb_uart_ldr_map", 32'(lmap), 32'h078F);
        check("arb_uart_rdy_map", 32'(rmap), 32'h2040);
        check("arb_uart_valid_map", 32'(umap), 32'h1020);
        check("arb_uart_rdata", rd, 32'hA5);
        cpu_access(32'h50, 32'd0, 4'b0, 0, 32'd0, rd, lat, vcnt, vgood, wen, ok);
        check("ldr_word_readback", rd, 32'h1234_5678);

        // Unmapped access: sticky error, zero data, no RAM/UART activity.
        check("err_before_fault", 32'(err_o), 32'd0);
        cpu_access(32'h2000_0000, 32'd0, 4'b0, 0, 32'd0, rd, lat, vcnt, vgood, wen, ok);
        check("fault_rdata", rd, 32'd0);
        check("fault_lat", 32'(lat), 32'd1);
        check("fault_err", 32'(err_o), 32'd1);
        check("fault_no_uart", 32'(vcnt), 32'd0);
        check("fault_no_ram_wr", 32'(wen), 32'd0);
        cpu_access(32'h0, 32'd0, 4'b0, 0, 32'd0, rd, lat, vcnt, vgood, wen, ok);
        check("err_sticky", 32'(err_o), 32'd1);

        // Reset during UART_WAIT drops uart_valid_o without a clock edge.
        mem_valid_i = 1'b1; mem_addr_i = UartBase + 32'd4; mem_wdata_i = 32'h77; mem_wstrb_i = 4'hF;
        repeat (3) @(negedge clk_i);
        check("mid_uart_valid", 32'(uart_valid_o), 32'd1);
        #2 reset_ni = 1'b0;
        #1;
        check("rst_async_uart_valid", 32'(uart_valid_o), 32'd0);
        check("rst_async_mem_ready", 32'(mem_ready_o), 32'd0);
        check("rst_async_err", 32'(err_o), 32'd0);
        mem_valid_i = 1'b0; mem_wstrb_i = 4'b0;
        @(negedge clk_i); reset_ni = 1'b1;
        rdy_cnt = 0;
        repeat (3) begin
            @(negedge clk_i);
            if (mem_ready_o || uart_valid_o) rdy_cnt++;
        end
        check("post_rst_quiet", 32'(rdy_cnt), 32'd0);
        @(posedge clk_i); #1;
        cpu_access(32'h10, 32'hCAFE_F00D, 4'hF, 0, 32'd0, rd, lat, vcnt, vgood, wen, ok);
        check("post_rst_idle_wr_lat", 32'(lat), 32'd1);
        cpu_access(32'h10, 32'd0, 4'b0, 0, 32'd0, rd, lat, vcnt, vgood, wen, ok);
        check("post_rst_rd", rd, 32'hCAFE_F00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/picorv_mem_ctrl.md
Name: picorv_mem_ctrl

Overview:
Memory-bus controller between the picorv32 native memory interface and the on-chip resources: a 1-read/1-write synchronous RAM with one-cycle read latency, and a UART register window. It decodes each CPU request, sequences the RAM read latency, and holds UART accesses until the UART handshake completes. It also arbitrates RAM write access between the CPU and a UART boot-loader port that streams program words into RAM.

Parameters:
RamWords, 256, RAM depth in 32-bit words; RAM byte window is 0 .. RamWords*4-1
UartBase, 32'h1000_0000, byte base of the 16-byte UART register window
LdrBurstMax, 4, maximum consecutive loader grants while a CPU request is pending

Ports:
clk_i  in  1  system clock; all state changes on the rising edge
reset_ni  in  1  asynchronous active-low reset
mem_valid_i  in  1  CPU request valid; held high by the CPU until mem_ready_o
mem_instr_i  in  1  CPU request is an instruction fetch (informational only)
mem_addr_i  in  32  CPU byte address; bits [1:0] ignored
mem_wdata_i  in  32  CPU write data
mem_wstrb_i  in  4  CPU byte strobes; 0 = read
mem_ready_o  out  1  one-cycle pulse completing the CPU request
mem_rdata_o  out  32  CPU read data; valid while mem_ready_o=1
ldr_valid_i  in  1  loader write request
ldr_addr_i  in  $clog2(RamWords)  loader word address
ldr_wdata_i  in  32  loader write data
ldr_ready_o  out  1  loader write accepted this cycle
ram_addr_o  out  $clog2(RamWords)  RAM word address
ram_wr_en_o  out  4  RAM byte write enables
ram_wr_data_o  out  32  RAM write data
ram_rd_data_i  in  32  RAM read data, valid one cycle after the address is presented
uart_valid_o  out  1  UART register access request
uart_we_o  out  1  UART access is a write (any strobe set)
uart_addr_o  out  2  UART register index (mem_addr_i[3:2])
uart_wdata_o  out  32  UART write data
uart_ready_i  in  1  UART access complete
uart_rdata_i  in  32  UART read data, valid with uart_ready_i
err_o  out  1  sticky flag: a CPU access hit an unmapped address

Behaviour:
- Reset (async, reset_ni=0): state=IDLE; burst counter=0; outputs mem_ready_o, ldr_ready_o, uart_valid_o, uart_we_o, err_o, ram_wr_en_o = 0; mem_rdata_o = 0. Reset asserted mid-transaction aborts it immediately, and uart_valid_o drops without waiting for the next clock edge.
- Address decode on mem_addr_i:
  - RAM: mem_addr_i < RamWords*4; ram_addr_o = mem_addr_i[$clog2(RamWords)+1:2].
  - UART: UartBase <= mem_addr_i < UartBase+16.
  - Any other address: fault.
- FSM states: IDLE, RD_WAIT, UART_WAIT, RESP.
- IDLE arbitration:
  - Loader wins if ldr_valid_i=1, unless mem_valid_i=1 and the burst counter equals LdrBurstMax.
  - Loader grant: ldr_ready_o=1 combinationally in the same cycle, ram_wr_en_o=4'hF, ram_addr_o=ldr_addr_i, ram_wr_data_o=ldr_wdata_i. Stay in IDLE. The burst counter increments (saturating) only when mem_valid_i=1.
  - The burst counter clears on any CPU grant, and whenever mem_valid_i=0.
- CPU grant from IDLE:
  - RAM write: ram_wr_en_o=mem_wstrb_i and ram_wr_data_o=mem_wdata_i this cycle; go to RESP.
  - RAM read: present ram_addr_o; go to RD_WAIT.
  - UART: go to UART_WAIT.
  - Fault: set err_o; load rdata 0; go to RESP.
- RD_WAIT: register ram_rd_data_i into mem_rdata_o; go to RESP.
- UART_WAIT:
  - Hold uart_valid_o=1 with a stable uart_we_o, uart_addr_o and uart_wdata_o until uart_ready_i=1.
  - On uart_ready_i=1, register uart_rdata_i (0 for writes), drop uart_valid_o and go to RESP. There is no timeout.
- RESP: mem_ready_o=1 for exactly one cycle with registered mem_rdata_o; next state IDLE. The loader is not granted in RD_WAIT, UART_WAIT or RESP.
- Latency, counted from the CPU grant edge:
  - RAM write: ready 1 cycle later.
  - RAM read: ready 2 cycles later.
  - UART: ready 1 cycle after uart_ready_i is sampled.
  - Fault: ready 1 cycle later.
- Outside a grant, ram_wr_en_o=0 and mem_rdata_o holds its last value.
- err_o clears only on reset.

Test Plan:
- Program load: loader writes 3fc00093, 0000a023, 0000a103, 00110113, 0020a023, ff5ff06f to words 0-5 with the CPU held in reset, then release -> CPU fetches match; stores to 0x3FC increment 0,1,2,...; each fetch shows mem_ready_o 2 cycles after the grant.
- RAM write then read: CPU sw 0xDEADBEEF to 0x3FC with wstrb=4'b0011, then lw -> read returns 0x0000BEEF (over zero-initialised RAM); write ready at +1, read ready at +2.
- UART access: CPU sw 0x41 to UartBase+0 with uart_ready_i delayed 5 cycles -> uart_valid_o high 6 cycles with uart_we_o=1 and uart_addr_o=0; mem_ready_o one cycle after; a lw from UartBase+4 returns uart_rdata_i=0x5A.
- Arbitration: ldr_valid_i held high continuously with the CPU requesting -> pattern of 4 loader grants, 1 CPU grant, repeated; no loader grant during RD_WAIT, UART_WAIT or RESP.
- Fault: CPU lw 0x2000_0000 -> err_o=1 (sticky), mem_rdata_o=0, ready at +1; no RAM or UART activity.
- Reset mid UART_WAIT: reset_ni=0 -> uart_valid_o=0 immediately; state IDLE after release; no spurious mem_ready_o.
